spu_issue_ctrl: RTL and testbench

Dual-issue scheduler between decode and the even/odd execution pipes. Accepts one instruction pair per handshake, with slot 0 older than slot 1. Steers each instruction to its pipe class and resolves three hazard types: structural (both slots need the same pipe), RAW (against in-flight producers, via a 128-entry latency scoreboard) and intra-pair RAW/WAW. Issues in order and drives registered per-pipe issue fields (opcode, register addresses, valid) toward the register file, forwarding macro and pipes.

---
 rtl/spu_issue_ctrl_pkg.sv | 62 ++++++
 rtl/spu_issue_ctrl_if.sv | 48 ++++
 rtl/spu_issue_ctrl_scoreboard.sv | 55 +++++
 rtl/spu_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spu_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_issue_ctrl_pkg.sv
// Shared types and constants for the SPU dual-issue scheduler.
// Optional performance counters are enabled with the SPU_ISSUE_PERF_EN macro.
package spu_issue_ctrl_pkg;

    localparam int OPCODE_LEN = 11;
    localparam int NUM_REGS   = 128;
    localparam int REG_AW     = 7;
    localparam int LAT_WD     = 3;

    localparam logic [LAT_WD-1:0] LAT_MAX = 3'd7;
    localparam logic [LAT_WD-1:0] LAT_ONE = 3'd1;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_e;

    typedef enum logic {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic                  valid;
        pipe_e                 pipe;
        logic [OPCODE_LEN-1:0] opcode;
        reg_addr_t             rt;
        reg_addr_t             ra;
        reg_addr_t             rb;
        reg_addr_t             rc;
        logic [2:0]            src_use;   // {ra, rb, rc}
        logic                  wr;
        logic [LAT_WD-1:0]     lat;
    } slot_t;

    typedef struct packed {
        logic                  valid;
        logic [OPCODE_LEN-1:0] opcode;
        reg_addr_t             ra;
        reg_addr_t             rb;
        reg_addr_t             rc;
        reg_addr_t             rt;
    } issue_t;

    // Counter value loaded at issue: a latency of 0 behaves like 1.
    function automatic logic [LAT_WD-1:0] ld_value(logic [LAT_WD-1:0] lat);
        return (lat == '0) ? '0 : lat - LAT_ONE;
    endfunction

    function automatic issue_t to_issue(slot_t s);
        return '{valid: 1'b1, opcode: s.opcode, ra: s.ra, rb: s.rb, rc: s.rc, rt: s.rt};
    endfunction

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/spu_issue_ctrl_if.sv
// Decode-to-scheduler pair handshake plus the registered per-pipe issue fields.
interface spu_issue_ctrl_if;
    import spu_issue_ctrl_pkg::*;

    logic                  flush;
    logic                  pair_valid;
    logic                  pair_ready;
    logic                  stall;

    logic                  s0_valid,  s1_valid;
    pipe_e                 s0_pipe,   s1_pipe;
    logic [OPCODE_LEN-1:0] s0_opcode, s1_opcode;
    reg_addr_t             s0_rt,     s1_rt;
    reg_addr_t             s0_ra,     s1_ra;
    reg_addr_t             s0_rb,     s1_rb;
    reg_addr_t             s0_rc,     s1_rc;
    logic [2:0]            s0_use,    s1_use;
    logic                  s0_wr,     s1_wr;
    logic [LAT_WD-1:0]     s0_lat,    s1_lat;

    logic                  ep_valid,  op_valid;
    logic [OPCODE_LEN-1:0] ep_opcode, op_opcode;
    reg_addr_t             ep_ra, ep_rb, ep_rc, ep_rt;
    reg_addr_t             op_ra, op_rb, op_rc, op_rt;

    logic [31:0]           perf_struct_stall, perf_raw_stall, perf_issued;

    modport master (
        output flush, pair_valid,
        output s0_valid, s0_pipe, s0_opcode, s0_rt, s0_ra, s0_rb, s0_rc, s0_use, s0_wr, s0_lat,
        output s1_valid, s1_pipe, s1_opcode, s1_rt, s1_ra, s1_rb, s1_rc, s1_use, s1_wr, s1_lat,
        input  pair_ready, stall,
        input  ep_valid, ep_opcode, ep_ra, ep_rb, ep_rc, ep_rt,
        input  op_valid, op_opcode, op_ra, op_rb, op_rc, op_rt,
        input  perf_struct_stall, perf_raw_stall, perf_issued
    );

    modport slave (
        input  flush, pair_valid,
        input  s0_valid, s0_pipe, s0_opcode, s0_rt, s0_ra, s0_rb, s0_rc, s0_use, s0_wr, s0_lat,
        input  s1_valid, s1_pipe, s1_opcode, s1_rt, s1_ra, s1_rb, s1_rc, s1_use, s1_wr, s1_lat,
        output pair_ready, stall,
        output ep_valid, ep_opcode, ep_ra, ep_rb, ep_rc, ep_rt,
        output op_valid, op_opcode, op_ra, op_rb, op_rc, op_rt,
        output perf_struct_stall, perf_raw_stall, perf_issued
    );

endinterface

// File: rtl/spu_issue_ctrl_scoreboard.sv
// Per-register latency scoreboard: counts cycles until each in-flight result
// is readable, and answers source-ready / WAW-clear lookups for both slots.
module spu_scoreboard
    import spu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld0_en,
    input  reg_addr_t         ld0_rt,
    input  logic [LAT_WD-1:0] ld0_lat,
    input  logic              ld1_en,
    input  reg_addr_t         ld1_rt,
    input  logic [LAT_WD-1:0] ld1_lat,
    input  slot_t             s0,
    input  slot_t             s1,
    output logic              s0_src_rdy,
    output logic              s1_src_rdy,
    output logic              s0_waw_clr,
    output logic              s1_waw_clr
);

    logic [LAT_WD-1:0] cnt_q [NUM_REGS];
    logic [LAT_WD-1:0] cnt_d [NUM_REGS];

    // Decrement every live counter; a load on the same register overrides it.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            // NOTE: default assignment first so every path drives cnt_d; no latch.
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_ONE : '0;
            if (ld1_en && ld1_rt == reg_addr_t'(r)) cnt_d[r] = ld_value(ld1_lat);
            if (ld0_en && ld0_rt == reg_addr_t'(r)) cnt_d[r] = ld_value(ld0_lat);
        end
    end

    // Counter array register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: this array is flops, not a RAM, and must reset so no stale hazard survives.
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign s0_src_rdy = (!s0.src_use[2] || cnt_q[s0.ra] == '0)
                     && (!s0.src_use[1] || cnt_q[s0.rb] == '0)
                     && (!s0.src_use[0] || cnt_q[s0.rc] == '0);
    assign s1_src_rdy = (!s1.src_use[2] || cnt_q[s1.ra] == '0)
                     && (!s1.src_use[1] || cnt_q[s1.rb] == '0)
                     && (!s1.src_use[0] || cnt_q[s1.rc] == '0);
    assign s0_waw_clr = !s0.wr || cnt_q[s0.rt] == '0;
    assign s1_waw_clr = !s1.wr || cnt_q[s1.rt] == '0;

endmodule

// File: rtl/spu_issue_ctrl.sv
// In-order dual-issue scheduler: steers slot 0/1 to even/odd pipes, resolves
// structural, scoreboard RAW/WAW and intra-pair hazards, and registers the
// per-pipe issue fields. Optional counters: define SPU_ISSUE_PERF_EN.
module spu_issue_ctrl
    import spu_issue_ctrl_pkg::*;
(
    input logic             clk,
    input logic             rst,
    spu_issue_ctrl_if.slave bus
);

    slot_t        s0, s1;
    issue_state_e state_q, state_d;
    issue_t       ep_q, ep_d, op_q, op_d;
    logic         s0_src_rdy, s1_src_rdy, s0_waw_clr, s1_waw_clr;
    logic         s0_sb_ok, s1_sb_ok, s1_raw_s0, s1_waw_s0, pipe_conflict;
    logic         active, s0_issue, s1_issue, s0_done, pair_ready;

    assign s0 = '{valid: bus.s0_valid, pipe: bus.s0_pipe, opcode: bus.s0_opcode,
                  rt: bus.s0_rt, ra: bus.s0_ra, rb: bus.s0_rb, rc: bus.s0_rc,
                  src_use: bus.s0_use, wr: bus.s0_wr, lat: bus.s0_lat};
    assign s1 = '{valid: bus.s1_valid, pipe: bus.s1_pipe, opcode: bus.s1_opcode,
                  rt: bus.s1_rt, ra: bus.s1_ra, rb: bus.s1_rb, rc: bus.s1_rc,
                  src_use: bus.s1_use, wr: bus.s1_wr, lat: bus.s1_lat};

    spu_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .ld0_en     (s0_issue && s0.wr),
        .ld0_rt     (s0.rt),
        .ld0_lat    (s0.lat),
        .ld1_en     (s1_issue && s1.wr),
        .ld1_rt     (s1.rt),
        .ld1_lat    (s1.lat),
        .s0         (s0),
        .s1         (s1),
        .s0_src_rdy (s0_src_rdy),
        .s1_src_rdy (s1_src_rdy),
        .s0_waw_clr (s0_waw_clr),
        .s1_waw_clr (s1_waw_clr)
    );

    assign s0_sb_ok      = s0_src_rdy && s0_waw_clr;
    assign s1_sb_ok      = s1_src_rdy && s1_waw_clr;
    assign pipe_conflict = (s0.pipe == s1.pipe);
    assign s1_raw_s0     = s0.wr && ((s1.src_use[2] && s1.ra == s0.rt)
                                  || (s1.src_use[1] && s1.rb == s0.rt)
                                  || (s1.src_use[0] && s1.rc == s0.rt));
    assign s1_waw_s0     = s0.wr && s1.wr && (s0.rt == s1.rt);
    assign active        = rst && bus.pair_valid && !bus.flush;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_PAIR;
        else      state_q <= state_d;
    end

    // FSM next state: split pairs park in ST_SECOND until slot 1 goes.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_PAIR;
        end else begin
            unique case (state_q)
                ST_PAIR:   if (s0_done && !pair_ready) state_d = ST_SECOND;
                ST_SECOND: if (pair_ready)             state_d = ST_PAIR;
                default:   state_d = ST_PAIR;
            endcase
        end
    end

    // FSM outputs: issue decisions, handshake, and pipe steering.
    always_comb begin
        s0_issue   = 1'b0;
        s1_issue   = 1'b0;
        s0_done    = 1'b0;
        pair_ready = 1'b0;
        if (active) begin
            unique case (state_q)
                ST_PAIR: begin
                    s0_issue   = s0.valid && s0_sb_ok;
                    s0_done    = !s0.valid || s0_issue;
                    s1_issue   = s0_done && s1.valid && s1_sb_ok
                              && (!s0_issue || (!pipe_conflict && !s1_raw_s0 && !s1_waw_s0));
                    pair_ready = s0_done && (!s1.valid || s1_issue);
                end
                ST_SECOND: begin
                    s1_issue   = s1.valid && s1_sb_ok;
                    pair_ready = !s1.valid || s1_issue;
                end
                default: ;
            endcase
        end
        ep_d = '0;
        op_d = '0;
        if (s0_issue) begin
            if (s0.pipe == PIPE_EVEN) ep_d = to_issue(s0);
            else                      op_d = to_issue(s0);
        end
        if (s1_issue) begin
            if (s1.pipe == PIPE_EVEN) ep_d = to_issue(s1);
            else                      op_d = to_issue(s1);
        end
    end

    // Issue field registers toward register file, forwarding and pipes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ep_q <= '0;
            op_q <= '0;
        end else begin
            ep_q <= ep_d;
            op_q <= op_d;
        end
    end

    assign bus.pair_ready = pair_ready;
    assign bus.stall      = rst && bus.pair_valid && !pair_ready;
    assign bus.ep_valid   = ep_q.valid;
    assign bus.ep_opcode  = ep_q.opcode;
    assign bus.ep_ra      = ep_q.ra;
    assign bus.ep_rb      = ep_q.rb;
    assign bus.ep_rc      = ep_q.rc;
    assign bus.ep_rt      = ep_q.rt;
    assign bus.op_valid   = op_q.valid;
    assign bus.op_opcode  = op_q.opcode;
    assign bus.op_ra      = op_q.ra;
    assign bus.op_rb      = op_q.rb;
    assign bus.op_rc      = op_q.rc;
    assign bus.op_rt      = op_q.rt;

`ifdef SPU_ISSUE_PERF_EN
    logic [31:0] perf_struct_q, perf_struct_d, perf_raw_q, perf_raw_d;
    logic [31:0] perf_issued_q, perf_issued_d;
    logic        struct_split, hazard_stall;

    // Classify the cycle's stall cause and advance the saturating counters.
    always_comb begin
        struct_split = active && state_q == ST_PAIR && s0_issue && s1.valid && s1_sb_ok
                    && !s1_raw_s0 && !s1_waw_s0 && pipe_conflict;
        hazard_stall = 1'b0;
        if (active) begin
            if (state_q == ST_PAIR)
                hazard_stall = (s0.valid && !s0_sb_ok)
                            || (s0_done && s1.valid
                                && (!s1_sb_ok || (s0_issue && (s1_raw_s0 || s1_waw_s0))));
            else
                hazard_stall = s1.valid && !s1_sb_ok;
        end
        perf_struct_d = sat_add(perf_struct_q, {1'b0, struct_split});
        perf_raw_d    = sat_add(perf_raw_q, {1'b0, hazard_stall});
        perf_issued_d = sat_add(perf_issued_q, {1'b0, s0_issue} + {1'b0, s1_issue});
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_struct_q <= '0;
            perf_raw_q    <= '0;
            perf_issued_q <= '0;
        end else begin
            perf_struct_q <= perf_struct_d;
            perf_raw_q    <= perf_raw_d;
            perf_issued_q <= perf_issued_d;
        end
    end

    assign bus.perf_struct_stall = perf_struct_q;
    assign bus.perf_raw_stall    = perf_raw_q;
    assign bus.perf_issued       = perf_issued_q;
`else
    assign bus.perf_struct_stall = '0;
    assign bus.perf_raw_stall    = '0;
    assign bus.perf_issued       = '0;
`endif

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Directed bench for spu_issue_ctrl: single-cycle vector table plus
// hand-written multi-cycle hazard, flush and reset sequences.
module tb_spu_issue_ctrl;
    import spu_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spu_issue_ctrl_if bus ();
    spu_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string                 name;
        slot_t                 s0;
        slot_t                 s1;
        logic                  rdy;
        logic                  ev;
        reg_addr_t             ert;
        logic [OPCODE_LEN-1:0] eop;
        logic                  ov;
        reg_addr_t             ort;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic slot_t mk(logic v, pipe_e p, logic [10:0] op, reg_addr_t rt,
                                 reg_addr_t ra, reg_addr_t rb, reg_addr_t rc,
                                 logic [2:0] u, logic w, logic [2:0] lat);
        return '{valid: v, pipe: p, opcode: op, rt: rt, ra: ra, rb: rb, rc: rc,
                 src_use: u, wr: w, lat: lat};
    endfunction

    task automatic drive(input slot_t a, input slot_t b);
        bus.s0_valid = a.valid; bus.s0_pipe = a.pipe; bus.s0_opcode = a.opcode;
        bus.s0_rt = a.rt; bus.s0_ra = a.ra; bus.s0_rb = a.rb; bus.s0_rc = a.rc;
        bus.s0_use = a.src_use; bus.s0_wr = a.wr; bus.s0_lat = a.lat;
        bus.s1_valid = b.valid; bus.s1_pipe = b.pipe; bus.s1_opcode = b.opcode;
        bus.s1_rt = b.rt; bus.s1_ra = b.ra; bus.s1_rb = b.rb; bus.s1_rc = b.rc;
        bus.s1_use = b.src_use; bus.s1_wr = b.wr; bus.s1_lat = b.lat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf_zero(input string tag);
        check({tag, ".perf_struct"}, bus.perf_struct_stall, 32'd0);
        check({tag, ".perf_raw"},    bus.perf_raw_stall,    32'd0);
        check({tag, ".perf_issued"}, bus.perf_issued,       32'd0);
    endtask

    initial begin
        slot_t z;
        slot_t a;
        slot_t b;
        z = '0;

        vecs[0] = '{"indep", mk(1, PIPE_EVEN, 11'h101, 7'd5, 7'd1, 7'd2, 7'd0, 3'b110, 1, 3'd1),
                             mk(1, PIPE_ODD,  11'h202, 7'd6, 7'd1, 7'd2, 7'd0, 3'b110, 1, 3'd1),
                    1, 1, 7'd5, 11'h101, 1, 7'd6};
        vecs[1] = '{"swap",  mk(1, PIPE_ODD,  11'h111, 7'd7, 7'd1, 7'd2, 7'd0, 3'b110, 1, 3'd1),
                             mk(1, PIPE_EVEN, 11'h222, 7'd8, 7'd1, 7'd2, 7'd0, 3'b110, 1, 3'd1),
                    1, 1, 7'd8, 11'h222, 1, 7'd7};
        vecs[2] = '{"none", z, z, 1, 0, 7'd0, 11'h000, 0, 7'd0};
        vecs[3] = '{"s0only", mk(1, PIPE_EVEN, 11'h333, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1), z,
                    1, 1, 7'd9, 11'h333, 0, 7'd0};
        vecs[4] = '{"s1only", mk(0, PIPE_EVEN, 11'h7FF, 7'd12, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd7),
                              mk(1, PIPE_EVEN, 11'h044, 7'd12, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1),
                    1, 1, 7'd12, 11'h044, 0, 7'd0};
        vecs[5] = '{"nowr",  mk(1, PIPE_EVEN, 11'h055, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 0, 3'd7),
                             mk(1, PIPE_ODD,  11'h066, 7'd13, 7'd3, 7'd0, 7'd0, 3'b100, 1, 3'd1),
                    1, 1, 7'd3, 11'h055, 1, 7'd13};
        vecs[6] = '{"nouse", mk(1, PIPE_EVEN, 11'h077, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1),
                             mk(1, PIPE_ODD,  11'h088, 7'd14, 7'd4, 7'd4, 7'd4, 3'b000, 1, 3'd1),
                    1, 1, 7'd4, 11'h077, 1, 7'd14};
        vecs[7] = '{"s1nowr", mk(1, PIPE_ODD, 11'h099, 7'd15, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1),
                              mk(1, PIPE_EVEN, 11'h0AA, 7'd15, 7'd0, 7'd0, 7'd0, 3'b000, 0, 3'd1),
                    1, 1, 7'd15, 11'h0AA, 1, 7'd15};

        // Reset: a valid pair presented during reset must not issue.
        bus.flush = 1'b0;
        bus.pair_valid = 1'b1;
        drive(vecs[0].s0, vecs[0].s1);
        #1;
        check("rst.ready", 32'(bus.pair_ready), 32'd0);
        check("rst.stall", 32'(bus.stall), 32'd0);
        tick();
        tick();
        check("rst.ep_valid", 32'(bus.ep_valid), 32'd0);
        check("rst.op_valid", 32'(bus.op_valid), 32'd0);
        check("rst.ep_rt", 32'(bus.ep_rt), 32'd0);
        check("rst.op_opcode", 32'(bus.op_opcode), 32'd0);
        check_perf_zero("rst");
        bus.pair_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Single-cycle vectors (latency 1 leaves the scoreboard clear).
        bus.pair_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].s0, vecs[i].s1);
            #1;
            check($sformatf("%s.ready", vecs[i].name), 32'(bus.pair_ready), 32'(vecs[i].rdy));
            check($sformatf("%s.stall", vecs[i].name), 32'(bus.stall), 32'(!vecs[i].rdy));
            tick();
            check($sformatf("%s.ep_valid", vecs[i].name), 32'(bus.ep_valid), 32'(vecs[i].ev));
            check($sformatf("%s.ep_rt", vecs[i].name), 32'(bus.ep_rt), 32'(vecs[i].ert));
            check($sformatf("%s.ep_opcode", vecs[i].name), 32'(bus.ep_opcode), 32'(vecs[i].eop));
            check($sformatf("%s.op_valid", vecs[i].name), 32'(bus.op_valid), 32'(vecs[i].ov));
            check($sformatf("%s.op_rt", vecs[i].name), 32'(bus.op_rt), 32'(vecs[i].ort));
        end

        // Independent pair with latencies 2 and 6.
        drive(mk(1, PIPE_EVEN, 11'h010, 7'd5, 7'd1, 7'd2, 7'd0, 3'b110, 1, 3'd2),
              mk(1, PIPE_ODD,  11'h020, 7'd6, 7'd1, 7'd2, 7'd0, 3'b110, 1, 3'd6));
        #1;
        check("ind.ready", 32'(bus.pair_ready), 32'd1);
        tick();
        check("ind.ep_valid", 32'(bus.ep_valid), 32'd1);
        check("ind.op_valid", 32'(bus.op_valid), 32'd1);
        check("ind.ep_rt", 32'(bus.ep_rt), 32'd5);
        check("ind.op_rt", 32'(bus.op_rt), 32'd6);

        // Scoreboard RAW: r10 latency 6, reader issues exactly 6 cycles later.
        drive(mk(1, PIPE_EVEN, 11'h030, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd6), z);
        #1;
        check("raw.prod_ready", 32'(bus.pair_ready), 32'd1);
        tick();
        drive(mk(1, PIPE_EVEN, 11'h031, 7'd20, 7'd10, 7'd0, 7'd0, 3'b100, 1, 3'd1), z);
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("raw.stall_t%0d", k), 32'(bus.stall), 32'd1);
            tick();
            check($sformatf("raw.ep_valid_t%0d", k), 32'(bus.ep_valid), 32'd0);
        end
        #1;
        check("raw.ready_t6", 32'(bus.pair_ready), 32'd1);
        check("raw.stall_t6", 32'(bus.stall), 32'd0);
        tick();
        check("raw.ep_valid_t6", 32'(bus.ep_valid), 32'd1);
        check("raw.ep_rt_t6", 32'(bus.ep_rt), 32'd20);

        // Structural: both even splits across two cycles.
        drive(mk(1, PIPE_EVEN, 11'h040, 7'd21, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1),
              mk(1, PIPE_EVEN, 11'h041, 7'd22, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1));
        #1;
        check("str.ready0", 32'(bus.pair_ready), 32'd0);
        check("str.stall0", 32'(bus.stall), 32'd1);
        tick();
        check("str.ep_rt0", 32'(bus.ep_rt), 32'd21);
        check("str.op_valid0", 32'(bus.op_valid), 32'd0);
`ifdef SPU_ISSUE_PERF_EN
        check("str.perf_struct", bus.perf_struct_stall, 32'd1);
`else
        check("str.perf_struct", bus.perf_struct_stall, 32'd0);
`endif
        check("str.ready1", 32'(bus.pair_ready), 32'd1);
        tick();
        check("str.ep_valid1", 32'(bus.ep_valid), 32'd1);
        check("str.ep_rt1", 32'(bus.ep_rt), 32'd22);

        // Intra-pair RAW on r3 with s0 latency 4.
        drive(mk(1, PIPE_EVEN, 11'h050, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd4),
              mk(1, PIPE_ODD,  11'h051, 7'd23, 7'd3, 7'd0, 7'd0, 3'b100, 1, 3'd1));
        #1;
        check("intra.ready0", 32'(bus.pair_ready), 32'd0);
        tick();
        check("intra.ep_rt0", 32'(bus.ep_rt), 32'd3);
        check("intra.op_valid0", 32'(bus.op_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("intra.ready_t%0d", k), 32'(bus.pair_ready), 32'd0);
            tick();
            check($sformatf("intra.op_valid_t%0d", k), 32'(bus.op_valid), 32'd0);
        end
        check("intra.ready_t4", 32'(bus.pair_ready), 32'd1);
        tick();
        check("intra.op_valid_t4", 32'(bus.op_valid), 32'd1);
        check("intra.op_rt_t4", 32'(bus.op_rt), 32'd23);

        // Flush while waiting in ST_SECOND; r3 (latency 5) keeps decaying.
        drive(mk(1, PIPE_EVEN, 11'h060, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd5),
              mk(1, PIPE_ODD,  11'h061, 7'd24, 7'd3, 7'd0, 7'd0, 3'b100, 1, 3'd1));
        tick();
        check("fl.ep_rt0", 32'(bus.ep_rt), 32'd3);
        bus.flush = 1'b1;
        #1;
        check("fl.ready", 32'(bus.pair_ready), 32'd0);
        tick();
        check("fl.op_valid", 32'(bus.op_valid), 32'd0);
        bus.flush = 1'b0;
        a = mk(1, PIPE_EVEN, 11'h062, 7'd25, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1);
        b = mk(1, PIPE_ODD,  11'h063, 7'd26, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd1);
        drive(a, b);
        #1;
        check("fl.pair_ready", 32'(bus.pair_ready), 32'd1);
        tick();
        check("fl.pair_ep", 32'(bus.ep_valid), 32'd1);
        check("fl.pair_op", 32'(bus.op_valid), 32'd1);
        drive(mk(1, PIPE_EVEN, 11'h064, 7'd27, 7'd0, 7'd3, 7'd0, 3'b010, 1, 3'd1), z);
        #1;
        check("fl.decay_stall2", 32'(bus.stall), 32'd1);
        tick();
        check("fl.decay_stall1", 32'(bus.stall), 32'd1);
        tick();
        check("fl.decay_ready", 32'(bus.pair_ready), 32'd1);
        tick();
        check("fl.decay_ep_rt", 32'(bus.ep_rt), 32'd27);

        // Reset while a reader of r10 waits with cnt[10] == 4.
        drive(mk(1, PIPE_EVEN, 11'h070, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1, 3'd6), z);
        tick();
        drive(mk(1, PIPE_EVEN, 11'h071, 7'd28, 7'd10, 7'd0, 7'd0, 3'b100, 1, 3'd1), z);
        #1;
        check("mrst.stall5", 32'(bus.stall), 32'd1);
        tick();
        check("mrst.stall4", 32'(bus.stall), 32'd1);
        rst = 1'b0;
        #1;
        check("mrst.ready_in_rst", 32'(bus.pair_ready), 32'd0);
        check("mrst.stall_in_rst", 32'(bus.stall), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check_perf_zero("mrst");
        check("mrst.ready", 32'(bus.pair_ready), 32'd1);
        check("mrst.stall", 32'(bus.stall), 32'd0);
        tick();
        check("mrst.ep_valid", 32'(bus.ep_valid), 32'd1);
        check("mrst.ep_rt", 32'(bus.ep_rt), 32'd28);
`ifdef SPU_ISSUE_PERF_EN
        check("mrst.perf_issued", bus.perf_issued, 32'd1);
`else
        check("mrst.perf_issued", bus.perf_issued, 32'd0);
`endif

        bus.pair_valid = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
